i2s_slave_tx: RTL and testbench
===============================

// Module: i2s_slave_tx
// PURPOSE
//  I2S slave transmitter: the transmit counterpart of i2s_slave. An external master drives BCK/WS;
//  this block drives SD with stereo samples in standard (Philips) I2S framing.
//  Runs in the pll_main_clk domain and oversamples the external BCK/WS.
//  Upstream (FIFO/trans_buffer side) supplies left/right words through a valid/ready holding register.
// PARAMETERS
//  DATA_WIDTH   32  bits per channel word, shifted MSB first
//  SYNC_STAGES  2   synchroniser flops on i2s_ck / i2s_ws before edge detection (>=2)
// PORTS
//  clk            in   1           system clock (pll_main_clk); must be >= 8x BCK frequency
//  nrst           in   1           asynchronous active-low reset
//  i2s_ck         in   1           external bit clock (asynchronous)
//  i2s_ws         in   1           external word select, 0 = left, 1 = right (asynchronous)
//  i2s_sd         out  1           serial data, changes after falling BCK
//  left_channel   in   DATA_WIDTH  left word offered by upstream
//  right_channel  in   DATA_WIDTH  right word offered by upstream
//  valid          in   1           upstream word pair valid
//  ready          out  1           holding register empty; pair accepted when valid && ready
//  underrun       out  1           one-clk pulse: left slot started with holding register empty
// BEHAVIOUR
//  Reset: i2s_sd=0, ready=1, underrun=0, holding empty, shift regs=0, state IDLE, bit counter=0.
//  Sync/edge: ck and ws each pass through SYNC_STAGES flops plus one history flop.
//   ck_rise/ck_fall are single-clk pulses.
//   Latency from a real BCK edge to the internal pulse is SYNC_STAGES+1 clk.
//  WS sampling: on ck_rise, ws_s is captured into ws_q. A difference from the previous ws_q
//   flags slot_start for the next ck_fall. This is the one-BCK Philips delay.
//  Holding reg: on valid && ready, store {left,right} and set full; ready = !full (registered).
//  State machine: IDLE -> LEFT on the first slot_start with ws_q=0.
//   LEFT <-> RIGHT on each subsequent slot_start.
//   A slot_start with ws_q=1 while in IDLE is ignored, so output always begins on a full frame.
//  Left slot start (on the ck_fall carrying slot_start with ws_q=0):
//   - full: load shift_l/shift_r from holding, clear full. ready rises the next clk.
//   - empty: load zeros and pulse underrun once. The IDLE->LEFT entry also checks and pulses.
//   - Same-clk valid with empty holding: the word is NOT bypassed. It is stored for the next
//     frame and underrun is still pulsed.
//  Right slot start: select shift_r. No handshake activity.
//  Shifting: on the ck_fall carrying slot_start, i2s_sd <= MSB of the selected word and bitcnt <= 1.
//   On each later ck_fall, i2s_sd <= next bit and bitcnt++.
//   Once bitcnt==DATA_WIDTH, i2s_sd <= 0 until the next slot_start (pads slots wider than DATA_WIDTH).
//   i2s_sd is registered and updates exactly 1 clk after the ck_fall pulse.
//  Short slot (WS toggles before DATA_WIDTH bits): the remaining bits are dropped and the new slot starts cleanly.
//  In IDLE: i2s_sd=0 and bitcnt held at 0.
//  The holding register still accepts data in IDLE, so one pair can be preloaded before BCK starts.
//  Reset mid-frame: all state returns to IDLE immediately, and output resumes only at the next left slot start.
// STRUCTURE
//  audio_defs.vh: `define I2S_WS_LEFT 1'b0, `define I2S_WS_RIGHT 1'b1, `define AUDIO_WORD_W 32.
//   The same defines are shared with i2s_slave / i2s_master.
//  Sub-module sync_edge (SYNC_STAGES param; outputs level, rise, fall) is instantiated for i2s_ck and i2s_ws.
//  Top body holds: holding reg, 2-bit state (IDLE/LEFT/RIGHT), shift regs, bitcnt ($clog2(DATA_WIDTH)+1 bits).
// TESTING
//  1 Preload L=32'h8000_0001, R=32'h7FFF_FFFE, then run BCK=64fs with clk=16x BCK.
//    -> SD decodes L/R exactly, MSB one BCK after WS falls; ready goes 1 after the load.
//  2 No valid ever asserted while BCK/WS run -> SD constant 0; underrun pulses once per frame, 1 clk wide.
//  3 BCK=96fs (48-bit slots), L=32'hA5A5_A5A5.
//    -> 32 data bits followed by 16 zeros per slot; no slip across 10 frames.
//  4 valid asserted on the same clk as the left slot start with holding empty.
//    -> underrun=1 and that frame is all zeros; the next frame carries the word.
//  5 Start BCK with WS=1 (mid right slot) -> SD stays 0 until the first WS 1->0; the first frame is complete.
//  6 Assert nrst=0 mid left slot -> SD=0 and ready=1 asynchronously.
//    After release, output restarts at the next left slot with a fresh pair.

Source files
------------

// File: rtl/i2s_slave_tx_pkg.sv
// i2s_slave_tx_pkg: shared I2S word-select encoding, word width and transmitter state type.
package i2s_slave_tx_pkg;
  localparam logic I2S_WS_LEFT = 1'b0;
  localparam logic I2S_WS_RIGHT = 1'b1;
  localparam int AUDIO_WORD_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } tx_state_t;
endpackage

// File: rtl/i2s_slave_tx_sync_edge.sv
// i2s_slave_tx_sync_edge: synchronise an asynchronous input and produce registered edge pulses.
//  clk   in   system clock
//  nrst  in   asynchronous active-low reset
//  d     in   asynchronous input
//  level out  synchronised level (SYNC_STAGES clk latency)
//  rise  out  one-clk pulse, SYNC_STAGES+1 clk after a rising edge of d
//  fall  out  one-clk pulse, SYNC_STAGES+1 clk after a falling edge of d
module i2s_slave_tx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  assign level = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync <= '0;
      hist <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      hist <= level;
      rise <= level & ~hist;
      fall <= ~level & hist;
    end
  end
endmodule

// File: rtl/i2s_slave_tx.sv
// i2s_slave_tx: I2S (Philips) slave transmitter driving SD from an external BCK/WS, fed by a valid/ready holding register.
//  clk            in   system clock, >= 8x BCK
//  nrst           in   asynchronous active-low reset
//  i2s_ck         in   external bit clock (asynchronous)
//  i2s_ws         in   external word select, 0 = left, 1 = right (asynchronous)
//  i2s_sd         out  serial data, registered, changes one clk after the internal BCK fall pulse
//  left_channel   in   left word offered upstream
//  right_channel  in   right word offered upstream
//  valid          in   upstream pair valid
//  ready          out  holding register empty
//  underrun       out  one-clk pulse when a left slot starts with the holding register empty
module i2s_slave_tx
  import i2s_slave_tx_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_WORD_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i2s_ck,
  input  logic                  i2s_ws,
  output logic                  i2s_sd,
  input  logic [DATA_WIDTH-1:0] left_channel,
  input  logic [DATA_WIDTH-1:0] right_channel,
  input  logic                  valid,
  output logic                  ready,
  output logic                  underrun
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  logic ck_rise, ck_fall, ws_s;
  logic ck_level_unused, ws_rise_unused, ws_fall_unused;
  logic ws_q, slot_pend, full;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, shift_l, shift_r;
  logic [CW-1:0] bitcnt;
  tx_state_t state;
  i2s_slave_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ck (
    .clk(clk), .nrst(nrst), .d(i2s_ck),
    .level(ck_level_unused), .rise(ck_rise), .fall(ck_fall)
  );
  i2s_slave_tx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ws (
    .clk(clk), .nrst(nrst), .d(i2s_ws),
    .level(ws_s), .rise(ws_rise_unused), .fall(ws_fall_unused)
  );
  // WS is sampled on BCK rise; a change arms slot_pend, consumed on the next BCK fall
  // (the one-BCK Philips delay). Accept and load are exclusive: accept needs ready, load needs full.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      ws_q      <= I2S_WS_LEFT;
      slot_pend <= 1'b0;
      full      <= 1'b0;
      ready     <= 1'b1;
      underrun  <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      shift_l   <= '0;
      shift_r   <= '0;
      bitcnt    <= '0;
      i2s_sd    <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (valid && ready) begin
        hold_l <= left_channel;
        hold_r <= right_channel;
        full   <= 1'b1;
        ready  <= 1'b0;
      end
      if (ck_rise) begin
        ws_q <= ws_s;
        if (ws_s != ws_q) slot_pend <= 1'b1;
      end
      if (ck_fall) begin
        slot_pend <= 1'b0;
        if (slot_pend && ws_q == I2S_WS_LEFT) begin
          state   <= ST_LEFT;
          bitcnt  <= CW'(1);
          shift_l <= full ? hold_l << 1 : '0;
          shift_r <= full ? hold_r : '0;
          i2s_sd  <= full & hold_l[DATA_WIDTH-1];
          if (full) begin
            full  <= 1'b0;
            ready <= 1'b1;
          end else underrun <= 1'b1;
        end else if (slot_pend && state != ST_IDLE) begin
          state   <= ST_RIGHT;
          bitcnt  <= CW'(1);
          i2s_sd  <= shift_r[DATA_WIDTH-1];
          shift_r <= shift_r << 1;
        end else if (state != ST_IDLE && bitcnt < CW'(DATA_WIDTH)) begin
          bitcnt <= bitcnt + 1'b1;
          i2s_sd <= state == ST_LEFT ? shift_l[DATA_WIDTH-1] : shift_r[DATA_WIDTH-1];
          if (state == ST_LEFT) shift_l <= shift_l << 1;
          else shift_r <= shift_r << 1;
        end else i2s_sd <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_slave_tx.sv
// tb_i2s_slave_tx: randomized self-checking bench; decodes SD like an I2S receiver and compares against a frame-level model.
module tb_i2s_slave_tx;
  localparam int DW = 32;
  logic clk = 1'b0, nrst = 1'b0, ck = 1'b0, ws = 1'b0, valid = 1'b0;
  logic [DW-1:0] lch = '0, rch = '0;
  logic sd, ready, underrun;
  int checks = 0, errors = 0, ur_cnt = 0;
  logic rx[$];
  logic [DW-1:0] exp_l[$], exp_r[$];
  logic m_full = 1'b0;
  logic [DW-1:0] m_l, m_r, late_l, late_r, fixed_l;
  bit use_fixed = 1'b0;
  int exp_ur;

  always #5 clk = ~clk;

  i2s_slave_tx dut (
    .clk(clk), .nrst(nrst), .i2s_ck(ck), .i2s_ws(ws), .i2s_sd(sd),
    .left_channel(lch), .right_channel(rch), .valid(valid), .ready(ready), .underrun(underrun)
  );

  always @(posedge clk) if (underrun === 1'b1) ur_cnt++;

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; ck = 1'b0; ws = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    m_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic preload(input logic [DW-1:0] l, input logic [DW-1:0] r);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL preload_ready_before: got %b expected 1", ready); end
    lch = l; rch = r; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    m_l = l; m_r = r; m_full = 1'b1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL preload_ready_after: got %b expected 0", ready); end
  endtask

  // One BCK period starting at a negedge of clk: BCK low 8 clk, sample SD, BCK high 8 clk.
  // act 1: pulse valid exactly on the clk where the slot start is processed (3 clk after BCK fall).
  // act 2: mid-slot refill of the holding register when the model says it is empty.
  task automatic bit_cycle(input logic w, input bit start, input int act);
    if (start) ws = w;
    ck = 1'b0;
    if (act == 1) begin
      repeat (3) @(negedge clk);
      lch = late_l; rch = late_r; valid = 1'b1;
      m_l = late_l; m_r = late_r; m_full = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
    end else if (act == 2) begin
      @(negedge clk);
      checks++;
      if (ready !== !m_full) begin errors++; $display("FAIL refill_ready: got %b expected %b", ready, !m_full); end
      if (!m_full) begin
        m_l = use_fixed ? fixed_l : $urandom;
        m_r = $urandom;
        lch = m_l; rch = m_r; valid = 1'b1; m_full = 1'b1;
      end
      @(negedge clk);
      valid = 1'b0;
      repeat (6) @(negedge clk);
    end else repeat (8) @(negedge clk);
    rx.push_back(sd);
    ck = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run(input string name, input int frames, input int sb, input bit lead, input bit refill, input int late_frame);
    int ur0, base, q, bad;
    logic [DW-1:0] word, ex;
    rx.delete(); exp_l.delete(); exp_r.delete();
    exp_ur = 0;
    ur0 = ur_cnt;
    if (lead) for (int b = 0; b < sb; b++) bit_cycle(1'b1, b == 0, 0);
    for (int f = 0; f < frames; f++) begin
      if (m_full) begin exp_l.push_back(m_l); exp_r.push_back(m_r); m_full = 1'b0; end
      else begin exp_l.push_back('0); exp_r.push_back('0); exp_ur++; end
      for (int b = 0; b < sb; b++)
        bit_cycle(1'b0, b == 0, (f == late_frame && b == 1) ? 1 : (refill && b == 4) ? 2 : 0);
      for (int b = 0; b < sb; b++) bit_cycle(1'b1, b == 0, 0);
    end
    bit_cycle(1'b1, 1'b0, 0);
    base = lead ? sb : 0;
    if (lead) begin
      bad = 0;
      for (int i = 0; i <= sb; i++) if (rx[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s_lead_zero: got %0d nonzero bits expected 0", name, bad); end
    end
    for (int f = 0; f < frames; f++)
      for (int c = 0; c < 2; c++) begin
        q = base + (2 * f + c) * sb;
        word = '0;
        for (int i = 0; i < DW; i++) word = {word[DW-2:0], rx[q + 1 + i]};
        ex = c == 0 ? exp_l[f] : exp_r[f];
        checks++;
        if (word !== ex) begin errors++; $display("FAIL %s_word f%0d c%0d: got %h expected %h", name, f, c, word, ex); end
        if (sb > DW) begin
          bad = 0;
          for (int i = q + DW + 1; i <= q + sb; i++) if (rx[i] !== 1'b0) bad++;
          checks++;
          if (bad != 0) begin errors++; $display("FAIL %s_pad f%0d c%0d: got %0d nonzero bits expected 0", name, f, c, bad); end
        end
      end
    checks++;
    if (ur_cnt - ur0 != exp_ur) begin errors++; $display("FAIL %s_underrun: got %0d clk expected %0d", name, ur_cnt - ur0, exp_ur); end
    checks++;
    if (ready !== !m_full) begin errors++; $display("FAIL %s_ready_end: got %b expected %b", name, ready, !m_full); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sd !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b expected 0", sd); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
  endtask

  task automatic test_basic();
    preload(32'h8000_0001, 32'h7FFF_FFFE);
    run("basic", 3, 32, 1'b1, 1'b1, -1);
  endtask

  task automatic test_no_valid();
    do_reset();
    run("novalid", 3, 32, 1'b1, 1'b0, -1);
  endtask

  task automatic test_wide_slot();
    preload(32'hA5A5_A5A5, $urandom);
    use_fixed = 1'b1; fixed_l = 32'hA5A5_A5A5;
    run("wide", 10, 48, 1'b0, 1'b1, -1);
    use_fixed = 1'b0;
  endtask

  task automatic test_late_valid();
    late_l = $urandom; late_r = $urandom;
    run("late", 3, 32, 1'b0, 1'b0, 1);
  endtask

  task automatic test_start_right();
    do_reset();
    preload($urandom, $urandom);
    run("startright", 2, 32, 1'b1, 1'b1, -1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    preload(32'hFFFF_FFFF, $urandom);
    for (int b = 0; b < 32; b++) bit_cycle(1'b1, b == 0, 0);
    for (int b = 0; b < 10; b++) bit_cycle(1'b0, b == 0, 0);
    checks++;
    if (sd !== 1'b1) begin errors++; $display("FAIL midreset_sd_before: got %b expected 1", sd); end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (sd !== 1'b0) begin errors++; $display("FAIL midreset_sd: got %b expected 0", sd); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", ready); end
    m_full = 1'b0;
    ck = 1'b0; ws = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    preload($urandom, $urandom);
    run("midreset", 2, 32, 1'b1, 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_valid();
    test_wide_slot();
    test_late_valid();
    test_start_right();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
